// File: rtl/cordic_rotation.sv
// Rotation-mode CORDIC: converts a phase in integer degrees into a saturated 8-bit I/Q pair.
// Six iterations after a quadrant pre-rotation; one conversion every 8 cycles at most.
module cordic_rotation #(
    parameter int AMPL = 39
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_start,
    input  logic signed [15:0] i_angle,
    output logic signed [7:0]  o_I,
    output logic signed [7:0]  o_Q,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROTATE,
        S_DONE
    } state_t;

    localparam logic signed [9:0]  AMPL_W   = 10'(AMPL);
    localparam logic signed [15:0] ANG_MAX  = 16'sd180;
    localparam logic signed [15:0] ANG_QUAD = 16'sd90;
    localparam logic [2:0]         K_LAST   = 3'd5;

    state_t             r_state;
    logic signed [9:0]  r_x;
    logic signed [9:0]  r_y;
    logic signed [15:0] r_z;
    logic [2:0]         r_k;
    logic               r_err;

    logic signed [15:0] w_atan;
    logic signed [9:0]  w_x_sh;
    logic signed [9:0]  w_y_sh;
    logic signed [9:0]  w_x_nxt;
    logic signed [9:0]  w_y_nxt;
    logic signed [15:0] w_z_nxt;
    logic signed [9:0]  w_x_load;
    logic signed [15:0] w_z_load;
    logic               w_bad;

    function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
        if (v > 10'sd127)
            return 8'sh7F;
        else if (v < -10'sd128)
            return 8'sh80;
        else
            return v[7:0];
    endfunction

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_atan = '0;
        case (r_k)
            3'd0:    w_atan = 16'sd45;
            3'd1:    w_atan = 16'sd27;
            3'd2:    w_atan = 16'sd14;
            3'd3:    w_atan = 16'sd7;
            3'd4:    w_atan = 16'sd3;
            3'd5:    w_atan = 16'sd2;
            default: w_atan = '0;
        endcase

        w_x_sh = r_x >>> r_k;
        w_y_sh = r_y >>> r_k;
        if (!r_z[15]) begin
            w_x_nxt = r_x - w_y_sh;
            w_y_nxt = r_y + w_x_sh;
            w_z_nxt = r_z - w_atan;
        end else begin
            w_x_nxt = r_x + w_y_sh;
            w_y_nxt = r_y - w_x_sh;
            w_z_nxt = r_z + w_atan;
        end

        // Fold the outer quadrants onto +/-90 so six iterations converge.
        w_bad = (i_angle > ANG_MAX) || (i_angle < -ANG_MAX);
        if (i_angle > ANG_QUAD) begin
            w_x_load = -AMPL_W;
            w_z_load = i_angle - ANG_MAX;
        end else if (i_angle < -ANG_QUAD) begin
            w_x_load = -AMPL_W;
            w_z_load = i_angle + ANG_MAX;
        end else begin
            w_x_load = AMPL_W;
            w_z_load = i_angle;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_k     <= '0;
            r_err   <= 1'b0;
            o_I     <= '0;
            o_Q     <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_x     <= w_x_load;
                        r_y     <= '0;
                        r_z     <= w_z_load;
                        r_k     <= '0;
                        r_err   <= w_bad;
                        o_busy  <= 1'b1;
                        r_state <= S_ROTATE;
                    end
                end
                S_ROTATE: begin
                    r_x <= w_x_nxt;
                    r_y <= w_y_nxt;
                    r_z <= w_z_nxt;
                    r_k <= r_k + 3'd1;
                    if (r_k == K_LAST) begin
                        o_I     <= r_err ? 8'sd0 : sat8(w_x_nxt);
                        o_Q     <= r_err ? 8'sd0 : sat8(w_y_nxt);
                        o_err   <= r_err;
                        o_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rotation.sv
// Directed-vector bench for cordic_rotation: table of angles with hand-derived I/Q,
// plus back-to-back, mid-conversion reset and input-hold sequences.
module tb_cordic_rotation;

    logic               clock;
    logic               reset;
    logic               i_start;
    logic signed [15:0] i_angle;
    logic signed [7:0]  o_I;
    logic signed [7:0]  o_Q;
    logic               o_valid;
    logic               o_busy;
    logic               o_err;

    int n_vec;
    int n_bad;

    cordic_rotation #(.AMPL(39)) dut (
        .clock  (clock),
        .reset  (reset),
        .i_start(i_start),
        .i_angle(i_angle),
        .o_I    (o_I),
        .o_Q    (o_Q),
        .o_valid(o_valid),
        .o_busy (o_busy),
        .o_err  (o_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic signed [15:0] angle;
        int                 exp_i;
        int                 exp_q;
        int                 exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse i_start for one edge (E0), scramble i_angle afterwards, and wait for o_valid.
    task automatic run_conv(input logic signed [15:0] ang,
                            output int ri, output int rq, output int re, output int lat);
        lat = -1;
        ri  = 0;
        rq  = 0;
        re  = 0;
        @(negedge clock);
        i_start = 1'b1;
        i_angle = ang;
        @(posedge clock);
        @(negedge clock);
        i_start = 1'b0;
        i_angle = 16'sd77;
        check("busy_after_E0", int'(o_busy), 1);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (o_valid) begin
                lat = n;
                break;
            end
        end
        ri = int'(o_I);
        rq = int'(o_Q);
        re = int'(o_err);
        if (lat > 0) begin
            @(posedge clock);
            @(negedge clock);
            check("valid_cleared_E7", int'(o_valid), 0);
            check("busy_cleared_E7", int'(o_busy), 0);
        end
    endtask

    initial begin
        int ai, aq, ae, lat;
        int first, second, pulses, seen;

        n_vec   = 0;
        n_bad   = 0;
        reset   = 1'b0;
        i_start = 1'b0;
        i_angle = '0;

        vecs[0] = '{angle:  16'sd0,    exp_i:  64, exp_q:   4, exp_err: 0};
        vecs[1] = '{angle:  16'sd90,   exp_i:   0, exp_q:  64, exp_err: 0};
        vecs[2] = '{angle:  16'sd180,  exp_i: -64, exp_q:  -4, exp_err: 0};
        vecs[3] = '{angle:  16'sd200,  exp_i:   0, exp_q:   0, exp_err: 1};
        vecs[4] = '{angle: -16'sd90,   exp_i:   2, exp_q: -63, exp_err: 0};
        vecs[5] = '{angle: -16'sd180,  exp_i: -64, exp_q:  -4, exp_err: 0};
        vecs[6] = '{angle: -16'sd181,  exp_i:   0, exp_q:   0, exp_err: 1};
        vecs[7] = '{angle:  16'sd45,   exp_i:  44, exp_q:  46, exp_err: 0};

        #12;
        check("rst_I", int'(o_I), 0);
        check("rst_Q", int'(o_Q), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_err", int'(o_err), 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_conv(vecs[i].angle, ai, aq, ae, lat);
            $display("vector %0d angle %0d: I=%0d Q=%0d err=%0d latency=%0d",
                     i, vecs[i].angle, ai, aq, ae, lat);
            check($sformatf("latency[%0d]", i), lat, 6);
            check($sformatf("I[%0d]", i), ai, vecs[i].exp_i);
            check($sformatf("Q[%0d]", i), aq, vecs[i].exp_q);
            check($sformatf("err[%0d]", i), ae, vecs[i].exp_err);
            check($sformatf("I_hold[%0d]", i), int'(o_I), vecs[i].exp_i);
            check($sformatf("Q_hold[%0d]", i), int'(o_Q), vecs[i].exp_q);
        end

        // i_start held high: accepts at E0, E8, E16; valid at E6 and E14 within 20 edges.
        first  = -1;
        second = -1;
        pulses = 0;
        @(negedge clock);
        i_start = 1'b1;
        i_angle = 16'sd0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (o_valid) begin
                pulses++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
                check("b2b_I", int'(o_I), 64);
                check("b2b_Q", int'(o_Q), 4);
            end
        end
        i_start = 1'b0;
        check("b2b_pulses", pulses, 2);
        check("b2b_first_edge", first, 6);
        check("b2b_second_edge", second, 14);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (!o_busy) begin
                seen = 1;
                break;
            end
        end
        check("b2b_returns_idle", seen, 1);

        // Reset asserted just after E3 of a conversion.
        run_conv(16'sd45, ai, aq, ae, lat);
        check("pre_reset_I", ai, 44);
        @(negedge clock);
        i_start = 1'b1;
        i_angle = 16'sd0;
        @(posedge clock);
        @(negedge clock);
        i_start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("midrst_I", int'(o_I), 0);
        check("midrst_Q", int'(o_Q), 0);
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_busy", int'(o_busy), 0);
        check("midrst_err", int'(o_err), 0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (o_valid || o_busy) seen++;
        end
        check("midrst_no_activity", seen, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        run_conv(16'sd0, ai, aq, ae, lat);
        check("postrst_latency", lat, 6);
        check("postrst_I", ai, 64);
        check("postrst_Q", aq, 4);
        check("postrst_err", ae, 0);

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
